// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU (alu_seq).
// Holds the opcode enum, FSM state enum and opcode width.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   // Opcode values are fixed: 13..15 are illegal
   // and produce a zero result in one cycle.
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_XOR  = 4'd3,
      ALU_NOR  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_SUB  = 4'd6,
      ALU_SLT  = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_LUI  = 4'd10,
      ALU_SLTU = 4'd11,
      ALU_MUL  = 4'd12
   } alu_op_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial
// product per cycle, WIDTH cycles per product.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_start     load operands, clear accumulator and count
//   i_a, i_b    multiplicand, multiplier (sampled on i_start)
//   o_done      all WIDTH iterations complete (count saturated)
//   o_res       low WIDTH bits of the product
//   o_hi_nz     high WIDTH bits of the product are non-zero
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_res,
   output logic             o_hi_nz
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;

   // Count rests at CNT_END when idle, so the unit
   // does no work until the next start.
   assign o_done  = (r_cnt == CNT_END);
   assign o_res   = r_acc[WIDTH-1:0];
   assign o_hi_nz = |r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= CNT_END;
      end else if (i_start) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (!o_done) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: parametrised ALU with registered valid/ready output
// and optional iterative multiplier (build macro ALU_MUL_EN).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   out_valid/out_ready result handshake (res, zero, overflow)
//   busy                multiply in progress
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    res,
   output logic                zero,
   output logic                overflow,
   output logic                busy
);

   localparam int HALF = WIDTH / 2;

   alu_op_t          w_op;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ovf;

   alu_state_t       r_state;
   alu_state_t       w_state_nxt;
   logic             w_out_free;
   logic             w_accept;
   logic             w_load;
   logic [WIDTH-1:0] w_load_res;
   logic             w_load_ovf;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_zero;
   logic             r_ovf;

   assign w_op    = alu_op_t'(op);
   assign w_shamt = b[SHAMT_W-1:0];
   assign w_sum   = a + b;
   assign w_diff  = a - b;

   // Single-cycle datapath; MUL and illegal codes fall
   // to the default (zero result, no overflow).
   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      unique case (w_op)
         ALU_AND:  w_alu_res = a & b;
         ALU_OR:   w_alu_res = a | b;
         ALU_XOR:  w_alu_res = a ^ b;
         ALU_NOR:  w_alu_res = ~(a | b);
         ALU_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLT: begin
            w_alu_res = {{(WIDTH-1){1'b0}},
                         ($signed(a) < $signed(b))};
         end
         ALU_SLTU: begin
            w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         end
         ALU_SRL:  w_alu_res = a >> w_shamt;
         ALU_SLL:  w_alu_res = a << w_shamt;
         ALU_SRA:  w_alu_res = $signed(a) >>> w_shamt;
         ALU_LUI:  w_alu_res = {b[HALF-1:0], {HALF{1'b0}}};
         default: begin
            w_alu_res = '0;
            w_alu_ovf = 1'b0;
         end
      endcase
   end

   // Output register can take a new value when empty or
   // being drained this same cycle.
   assign w_out_free = !r_out_valid || out_ready;
   assign in_ready   = (r_state == IDLE) && w_out_free;
   assign w_accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
   logic             w_op_is_mul;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_res;
   logic             w_mul_hi;

   assign w_op_is_mul = (w_op == ALU_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_mul_start),
      .i_a     (a),
      .i_b     (b),
      .o_done  (w_mul_done),
      .o_res   (w_mul_res),
      .o_hi_nz (w_mul_hi)
   );

   assign busy = (r_state == MUL_RUN);
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_res  = w_alu_res;
      w_load_ovf  = w_alu_ovf;
`ifdef ALU_MUL_EN
      w_mul_start = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
`ifdef ALU_MUL_EN
               if (w_op_is_mul) begin
                  w_mul_start = 1'b1;
                  w_state_nxt = MUL_RUN;
               end else begin
                  w_load = 1'b1;
               end
`else
               w_load = 1'b1;
`endif
            end
         end
         MUL_RUN: begin
`ifdef ALU_MUL_EN
            // A finished product waits here (count
            // saturated) until the output register frees.
            if (w_mul_done && w_out_free) begin
               w_load      = 1'b1;
               w_load_res  = w_mul_res;
               w_load_ovf  = w_mul_hi;
               w_state_nxt = IDLE;
            end
`else
            w_state_nxt = IDLE;
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_res       <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_res       <= w_load_res;
         r_zero      <= ~|w_load_res;
         r_ovf       <= w_load_ovf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign res       = r_res;
   assign zero      = r_zero;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32).
// Builds with or without ALU_MUL_EN.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] res;
   logic         zero;
   logic         overflow;
   logic         busy;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .zero      (zero),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ovf;
   } vec_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
      end
   endtask

   // Monitor: every transfer (out_valid && out_ready)
   // pops one expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got %h expected none",
                        res);
            end else begin
               e = q.pop_front();
               chk("res", res, e.res);
               chk("zero", {31'd0, zero}, {31'd0, e.zero});
               chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
         end
      end
   end

   task automatic send(input logic [3:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic [W-1:0] er,
                       input logic eo,
                       input bit push,
                       output int waited);
      exp_t e;
      @(negedge clk);
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
         in_valid = 1'b0;
      end else begin
         if (push) begin
            e.res  = er;
            e.zero = (er == '0);
            e.ovf  = eo;
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2;
      chk("queue_empty", W'(q.size()), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   vec_t vecs [0:17];
   int   w;
   int   bad;

   initial begin
      vecs = '{
         '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
         '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
         '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
         '{ALU_AND,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
         '{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0},
         '{ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
         '{ALU_NOR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0},
         '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
         '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
         '{ALU_SRA,  32'h4000_0000, 32'h0000_0024, 32'h0400_0000, 1'b0},
         '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0},
         '{ALU_SLL,  32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1'b0},
         '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
         '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
         '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
         '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
         '{ALU_LUI,  32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000, 1'b0},
         '{4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}
      };

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_res", res, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // ADD overflow, one-cycle latency
      send(ALU_ADD, 32'h7FFF_FFFF, 32'h1,
           32'h8000_0000, 1'b1, 1'b1, w);
      chk("add_latency", {31'd0, out_valid}, 32'd1);

      // Back-to-back AND then OR: no stall
      send(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00,
           32'h0000_F000, 1'b0, 1'b1, w);
      send(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00,
           32'h0000_FFF0, 1'b0, 1'b1, w);
      chk("b2b_no_stall", W'(w), 32'd0);

      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].res, vecs[i].ovf, 1'b1, w);
      end
      send(4'd13, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 1'b1, w);
      chk("illegal_latency", {31'd0, out_valid}, 32'd1);
      drain();

      // Backpressure: result held, next op waits for out_ready
      @(negedge clk);
      out_ready = 1'b0;
      send(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b1, w);
      repeat (3) @(negedge clk);
      #1;
      chk("held_res", res, 32'h30);
      chk("held_valid", {31'd0, out_valid}, 32'd1);
      chk("held_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      op = ALU_XOR;
      a = 32'hFF00_FF00;
      b = 32'h0F0F_0F0F;
      in_valid = 1'b1;
      #1;
      chk("held_no_accept", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("ready_rise_accept", {31'd0, in_ready}, 32'd1);
      q.push_back('{32'hF00F_F00F, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("next_loaded", res, 32'hF00F_F00F);
      drain();

`ifdef ALU_MUL_EN
      // MUL 0x10000 * 0x10000: low half 0, high half non-zero
      send(ALU_MUL, 32'h0001_0000, 32'h0001_0000,
           32'h0, 1'b1, 1'b1, w);
      bad = 0;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         #1;
         if (busy !== 1'b1 || in_ready !== 1'b0 ||
             out_valid !== 1'b0) bad++;
      end
      chk("mul_busy_window", W'(bad), 32'd0);
      @(negedge clk);
      #1;
      chk("mul_latency", {31'd0, out_valid}, 32'd1);
      chk("mul_busy_done", {31'd0, busy}, 32'd0);
      drain();

      // MUL completing into a stalled consumer
      @(negedge clk);
      out_ready = 1'b0;
      send(ALU_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1'b1, w);
      bad = 0;
      while (!out_valid && bad < 60) begin
         @(negedge clk);
         #1;
         bad++;
      end
      repeat (2) @(negedge clk);
      #1;
      chk("mul_held_res", res, 32'd42);
      chk("mul_held_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a multiply
      send(ALU_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, w);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mulrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mulrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (40) @(negedge clk);
      #1;
      chk("mulrst_no_result", {31'd0, out_valid}, 32'd0);
`else
      // Opcode 12 without the multiplier is illegal
      send(ALU_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, w);
      chk("mul_off_latency", {31'd0, out_valid}, 32'd1);
      chk("mul_off_busy", {31'd0, busy}, 32'd0);
      drain();
`endif

      // Reset while a stalled result is pending
      @(negedge clk);
      out_ready = 1'b0;
      send(ALU_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, w);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_res", res, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);

      send(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, w);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
